// File: rtl/fact_sequencer_if.sv
// fact_sequencer_if: groups the three handshakes of the factorial request
// sequencer.
//   req_*  : request in (valid/ready, operand n)
//   fact_* : engine side (go pulse and operand out; done/error/product in)
//   rsp_*  : response out (valid/ready, product/error/timeout)
// The slave modport is the sequencer's view. The master modport is the
// surrounding environment's view: the front-end, the engine and the consumer.
interface fact_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_n;

  logic        fact_go;
  logic [31:0] fact_n;
  logic        fact_done;
  logic        fact_error;
  logic [31:0] fact_product;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_product;
  logic        rsp_error;
  logic        rsp_timeout;

  modport slave (
    input  req_valid, req_n, fact_done, fact_error, fact_product, rsp_ready,
    output req_ready, fact_go, fact_n, rsp_valid, rsp_product, rsp_error, rsp_timeout
  );

  modport master (
    output req_valid, req_n, fact_done, fact_error, fact_product, rsp_ready,
    input  req_ready, fact_go, fact_n, rsp_valid, rsp_product, rsp_error, rsp_timeout
  );
endinterface

// File: rtl/fact_sequencer.sv
// fact_sequencer: buffers factorial requests in a DEPTH-entry FIFO. It issues
// them one at a time to the factorial engine, and returns each result on a
// valid/ready response port.
// Operands above 12 are rejected locally without starting the engine. An
// engine that does not finish within TIMEOUT cycles of the go pulse produces
// a timeout response.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        fact_sequencer_if.slave (request, engine and response handshakes)
//   busy       FSM not idle, or requests still queued
//   rsp_count  number of completed response handshakes (wraps)
module fact_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  fact_sequencer_if.slave       bus,
  output logic                  busy,
  output logic [15:0]           rsp_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GO, WAIT_CLR, WAIT, RESP} state_t;
  typedef struct packed {
    logic [31:0] product;
    logic        error;
    logic        timeout;
  } rsp_t;

  state_t                 state, state_nxt;
  rsp_t                   rsp, rsp_nxt;
  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [TW-1:0]          tmo_cnt;
  logic [31:0]            head;
  logic                   push, pop, load_n, tmo_hit, fin;

  assign bus.req_ready = (count != FULL);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) || (count != '0);
  assign fin           = bus.fact_done || bus.fact_error;

  // Timeout fires on the cycle the counter would step onto TIMEOUT-1. This
  // puts rsp_valid exactly TIMEOUT cycles after the go pulse.
  assign tmo_hit = (tmo_cnt + TW'(1)) == TMO_END;

  assign bus.rsp_product = rsp.product;
  assign bus.rsp_error   = rsp.error;
  assign bus.rsp_timeout = rsp.timeout;

  always_comb begin
    state_nxt = state;
    rsp_nxt   = rsp;
    load_n    = 1'b0;
    unique case (state)
      IDLE: if (count != '0) begin
        if (head > 32'd12) begin
          rsp_nxt.product = '0;
          rsp_nxt.error   = 1'b1;
          rsp_nxt.timeout = 1'b0;
          state_nxt       = RESP;
        end else begin
          load_n    = 1'b1;
          state_nxt = GO;
        end
      end
      GO: state_nxt = WAIT_CLR;
      // Flags still high here belong to the previous operation. Only a
      // timeout can end this state early.
      WAIT_CLR: if (tmo_hit) begin
        rsp_nxt.product = '0;
        rsp_nxt.error   = 1'b0;
        rsp_nxt.timeout = 1'b1;
        state_nxt       = RESP;
      end else if (!fin) begin
        state_nxt = WAIT;
      end
      // Completion is tested first, so it wins over a same-cycle timeout.
      WAIT: if (fin) begin
        rsp_nxt.product = bus.fact_error ? 32'd0 : bus.fact_product;
        rsp_nxt.error   = bus.fact_error;
        rsp_nxt.timeout = 1'b0;
        state_nxt       = RESP;
      end else if (tmo_hit) begin
        rsp_nxt.product = '0;
        rsp_nxt.error   = 1'b0;
        rsp_nxt.timeout = 1'b1;
        state_nxt       = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage needs no reset: the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rsp         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      bus.fact_go <= 1'b0;
      bus.fact_n  <= '0;
      bus.rsp_valid <= 1'b0;
      rsp_count   <= '0;
    end else begin
      state         <= state_nxt;
      rsp           <= rsp_nxt;
      bus.fact_go   <= (state_nxt == GO);
      bus.rsp_valid <= (state_nxt == RESP);
      if (load_n) bus.fact_n <= head;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (state == GO)
        tmo_cnt <= '0;
      else if (state == WAIT_CLR || state == WAIT)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (state == RESP && bus.rsp_ready) rsp_count <= rsp_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_fact_sequencer.sv
// tb_fact_sequencer: randomized and directed bench for fact_sequencer.
// A behavioural engine model answers the go pulses. A queue of expected
// responses is built from the operand rules when each request is accepted.
module tb_fact_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [15:0] rsp_count;

  fact_sequencer_if bus();

  fact_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // ---------------- engine model ----------------
  typedef enum {ENG_NORMAL, ENG_HANG, ENG_STALE} eng_mode_t;
  eng_mode_t   eng_mode   = ENG_NORMAL;
  bit          err_inject = 1'b0;
  int          eng_cnt    = 0;
  int          stale_cnt  = 0;
  logic [31:0] eng_n      = '0;

  always @(negedge clk) begin
    if (!reset) begin
      bus.fact_done = 1'b0; bus.fact_error = 1'b0; bus.fact_product = '0;
      eng_cnt = 0; stale_cnt = 0;
    end else if (bus.fact_go) begin
      eng_n = bus.fact_n;
      if (eng_mode == ENG_STALE) stale_cnt = 3;
      else begin bus.fact_done = 1'b0; bus.fact_error = 1'b0; end
      eng_cnt = (eng_mode == ENG_HANG) ? 0 : int'($urandom_range(2, 6));
    end else if (stale_cnt > 0) begin
      stale_cnt--;
      if (stale_cnt == 0) begin bus.fact_done = 1'b0; bus.fact_error = 1'b0; end
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        if (err_inject && eng_n == 32'd7) begin
          bus.fact_error = 1'b1; bus.fact_product = 32'hDEAD_BEEF;
        end else begin
          bus.fact_done = 1'b1; bus.fact_product = fact(eng_n);
        end
      end
    end
  end

  // ---------------- response-ready driver ----------------
  bit   rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] n;
    logic [31:0] prod;
    logic        err;
    logic        to;
    int          acc_cyc;
    bit          timed;
  } exp_t;
  exp_t exp_q[$];
  int   go_cycs[$];

  function automatic exp_t mk_exp(input logic [31:0] n, input bit timed);
    exp_t e;
    e.n = n; e.prod = '0; e.err = 1'b0; e.to = 1'b0;
    e.acc_cyc = cyc; e.timed = timed;
    if (n > 32'd12)                         e.err  = 1'b1;
    else if (eng_mode == ENG_HANG)          e.to   = 1'b1;
    else if (err_inject && n == 32'd7)      e.err  = 1'b1;
    else                                    e.prod = fact(n);
    return e;
  endfunction

  // ---------------- monitor ----------------
  int   go_cnt_req  = 0;
  int   last_go_cyc = 0;
  int   n_rsp       = 0;
  logic prev_valid  = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      go_cnt_req = 0; n_rsp = 0; prev_valid = 1'b0;
    end else begin
      if (bus.fact_go) begin
        go_cnt_req++;
        last_go_cyc = cyc;
        go_cycs.push_back(cyc);
        if (exp_q.size() == 0) chk("go_unexpected", 32'd1, 32'd0);
        else begin
          chk("go_fact_n", bus.fact_n, exp_q[0].n);
          if (exp_q[0].timed) chk("go_latency", 32'(cyc - exp_q[0].acc_cyc), 32'd2);
        end
      end
      if (bus.rsp_valid && !prev_valid && exp_q.size() > 0) begin
        if (exp_q[0].to)
          chk("timeout_latency", 32'(cyc - last_go_cyc), 32'(TIMEOUT));
        else if (exp_q[0].n > 32'd12 && exp_q[0].timed)
          chk("reject_latency", 32'(cyc - exp_q[0].acc_cyc), 32'd2);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_product", bus.rsp_product, e.prod);
          chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
          chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
          chk("go_pulses", 32'(go_cnt_req), (e.n > 32'd12) ? 32'd0 : 32'd1);
          chk("rsp_count", 32'(rsp_count), 32'(16'(n_rsp)));
        end
        n_rsp++;
        go_cnt_req = 0;
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] n);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_n     = n;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back(mk_exp(n, !busy && exp_q.size() == 0));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rn;
    int          acc;
    logic [31:0] burst [7];

    bus.req_valid = 1'b0;
    bus.req_n     = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fact_go", 32'(bus.fact_go), 32'd0);
    chk("rst_fact_n", bus.fact_n, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_product", bus.rsp_product, 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // single n = 5
    send(32'd5);
    drain(200);
    chk("t1_rsp_count", 32'(rsp_count), 32'd1);

    // back-to-back n = 0, n = 1
    go_cycs.delete();
    send(32'd0);
    send(32'd1);
    drain(200);
    chk("t2_go_count", 32'(go_cycs.size()), 32'd2);
    if (go_cycs.size() == 2)
      chk("t2_go_gap_ge4", 32'(go_cycs[1] - go_cycs[0] >= 4), 32'd1);

    // local reject
    go_cycs.delete();
    send(32'd13);
    drain(200);
    chk("t3_no_go", 32'(go_cycs.size()), 32'd0);

    // hung engine, then normal service
    eng_mode = ENG_HANG;
    send(32'd9);
    drain(300);
    eng_mode = ENG_NORMAL;
    send(32'd4);
    drain(200);

    // back-pressure: 7 attempted, 5 accepted
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    burst = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd8};
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_n     = burst[0];
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(mk_exp(bus.req_n, 1'b0));
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 7) bus.req_n = burst[acc];
      else bus.req_valid = 1'b0;
    end
    chk("t5_accepted", 32'(acc), 32'd5);
    chk("t5_req_ready_full", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    rdy_fixed = 1'b1;
    drain(400);

    // stale done from previous op must be ignored
    eng_mode = ENG_STALE;
    send(32'd8);
    drain(200);
    eng_mode = ENG_NORMAL;

    // reset pulse mid-WAIT with requests queued
    eng_mode = ENG_HANG;
    send(32'd10);
    send(32'd3);
    send(32'd2);
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_fact_go", 32'(bus.fact_go), 32'd0);
    chk("mid_rst_fact_n", bus.fact_n, 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("mid_rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    exp_q.delete();
    eng_mode = ENG_NORMAL;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    send(32'd6);
    drain(200);
    chk("post_rst_rsp_count", 32'(rsp_count), 32'd1);

    // randomized traffic
    rdy_rand   = 1'b1;
    err_inject = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rn = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rn = $urandom() | 32'h8000_0000;
      send(rn);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain(3000);
    rdy_rand   = 1'b0;
    err_inject = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fact_sequencer.md
# fact_sequencer

Request-side sequencer for the factorial engine. It buffers incoming n requests in a small FIFO and issues them one at a time to the engine over the go/n/done/error/product handshake. It collects each result and returns it on a valid/ready response port. Requests with n > 12 are rejected locally, and a hung engine is caught by a timeout. It sits between a bus/test front-end and `factorial`, driving `factorial.go` and `factorial.n` and consuming its `done`, `error` and `product`.

## Interface
- DEPTH, 4: request FIFO entries (power of 2, ≥2).
- TIMEOUT, 64: max cycles from go pulse to engine completion before a timeout response.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full; request accepted on an edge where req_valid && req_ready.
- req_n  in  32  factorial operand.
- fact_go  out  1  one-cycle start pulse to the engine.
- fact_n  out  32  operand to the engine; held stable from GO until RESP is exited.
- fact_done  in  1  engine done (level; stays high until the next go).
- fact_error  in  1  engine error (level).
- fact_product  in  32  engine result; valid while fact_done is high.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_product  out  32  result; 0 on any error or timeout.
- rsp_error  out  1  engine error, or local reject (n > 12).
- rsp_timeout  out  1  engine did not complete within TIMEOUT cycles.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- rsp_count  out  16  completed responses (handshakes); wraps at 65535 → 0.

## Operation
- **FIFO**
  - Circular buffer with DEPTH entries, read and write pointers, and an occupancy count of clog2(DEPTH)+1 bits.
  - Push on an accepted request. Pop only when the FSM leaves IDLE.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full (req_ready = 0). No pop when empty.
- **FSM states:** IDLE, GO, WAIT_CLR, WAIT, RESP.
- **IDLE**
  - If FIFO is non-empty and head ≤ 12: pop, load fact_n, go to GO.
  - If FIFO is non-empty and head > 12 (unsigned 32-bit compare): pop, load rsp_error = 1, rsp_product = 0, rsp_timeout = 0, go to RESP. No go pulse is issued.
- **GO**
  - fact_go = 1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT_CLR.
- **WAIT_CLR**
  - Waits until fact_done = 0 and fact_error = 0. This discards stale completion flags from the previous operation.
  - When both are low, go to WAIT.
- **WAIT**
  - On the first cycle where fact_done or fact_error is high, capture into the response registers:
    - rsp_product = fact_error ? 0 : fact_product
    - rsp_error = fact_error
    - rsp_timeout = 0
  - Then go to RESP.
- **Timeout**
  - The counter increments every cycle in WAIT_CLR and WAIT.
  - When the count reaches TIMEOUT-1 without completion: rsp_timeout = 1, rsp_error = 0, rsp_product = 0, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- **RESP**
  - rsp_valid = 1, response fields held stable.
  - On rsp_ready: increment rsp_count, go to IDLE.
- Only one engine operation is ever outstanding.
- **Reset values (reset = 0, asynchronous)**
  - FSM in IDLE, FIFO empty, pointers 0.
  - fact_go = 0, fact_n = 0.
  - rsp_valid = 0, rsp_product = 0, rsp_error = 0, rsp_timeout = 0.
  - rsp_count = 0, busy = 0.
  - req_ready = 1 after reset deasserts.
  - Reset mid-operation discards the in-flight request and all queued requests. The engine shares the same reset.

## Timing
- All outputs are registered except req_ready (derived from the count) and busy (derived from state and count).
- Accepted request at edge k: the FIFO is non-empty in cycle k+1; IDLE pops at edge k+2.
- Local reject: rsp_valid = 1 from cycle k+2.
- Engine path:
  - fact_go is high in cycle k+2.
  - WAIT_CLR occupies at least one cycle (cycle k+3).
  - If the engine raises done at cycle d, rsp_valid rises at cycle d+1.
- Response handshake at edge r: IDLE in r+1. The next go pulse can occur no earlier than cycle r+2.
- fact_go never asserts outside GO, so there is never more than one pulse per request.

## Test plan
- Push n = 5 with rsp_ready = 1 → exactly one fact_go pulse with fact_n = 5; response rsp_product = 120, rsp_error = 0, rsp_timeout = 0; rsp_count = 1.
- Push n = 0, then n = 1, back-to-back → two responses in order, each with rsp_product = 1; two go pulses separated by at least 4 cycles.
- Push n = 13 → no fact_go pulse; rsp_valid 2 cycles after acceptance with rsp_error = 1, rsp_product = 0.
- Engine model never raises done/error, TIMEOUT = 64 → rsp_valid with rsp_timeout = 1 exactly 64 cycles after the go pulse; the next request is then serviced normally.
- Hold rsp_ready = 0 and push 7 requests continuously → 5 accepted (1 in RESP, 4 queued), then req_ready = 0; release rsp_ready → all 5 responses drain in FIFO order.
- Engine model holds done high from the previous op for 3 cycles after go, and reset = 0 is pulsed mid-WAIT:
  - Stale done is ignored; the correct product is returned.
  - After the reset pulse, all outputs are at reset values asynchronously and the FIFO is empty.
